// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and recovered timing outputs of the VGA sync decoder.
// master drives the raw syncs, slave is the decoder.
interface vga_sync_decoder_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       de;
  logic       frame_start;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       locked;
  logic       sync_err;

  modport master (
    output hsync_in, vsync_in,
    input  xpos, ypos, de, frame_start,
    input  line_len, frame_lines, locked, sync_err
  );

  modport slave (
    input  hsync_in, vsync_in,
    output xpos, ypos, de, frame_start,
    output line_len, frame_lines, locked, sync_err
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from raw VGA syncs and
// tracks lock against the expected line and frame lengths.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 521,
  parameter int H_DE_START  = 144,
  parameter int H_DE_END    = 784,
  parameter int V_DE_START  = 31,
  parameter int V_DE_END    = 511,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             new_clk_25,
  input  logic             reset,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [10:0] C_HT  = 11'(H_TOTAL);
  localparam logic [10:0] C_VT  = 11'(V_TOTAL);
  localparam logic [9:0]  C_HDS = 10'(H_DE_START);
  localparam logic [9:0]  C_HDE = 10'(H_DE_END);
  localparam logic [9:0]  C_VDS = 10'(V_DE_START);
  localparam logic [9:0]  C_VDE = 10'(V_DE_END);
  localparam logic [1:0]  C_LF  = 2'(LOCK_FRAMES);
  localparam logic [9:0]  C_MAX = 10'h3ff;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_good;
  logic [1:0] w_good_nxt;

  logic       r_hs1, r_hs2, r_hprev;
  logic       r_vs1, r_vs2, r_vlast;
  logic [9:0] r_xpos, r_ypos;
  logic [9:0] r_line_len, r_frame_lines;
  logic       r_de, r_fs, r_locked, r_err;

  logic        w_hfall, w_frame, w_fail, w_bad;
  logic        w_de_nxt;
  logic [10:0] w_xinc, w_yinc;
  logic [9:0]  w_xsat, w_ysat;
  logic [9:0]  w_x_nxt, w_y_nxt;

  assign w_hfall = r_hprev & ~r_hs2;
  // A frame starts on the first hsync edge that sees vsync low.
  assign w_frame = w_hfall & ~r_vs2 & r_vlast;

  assign w_xinc = {1'b0, r_xpos} + 11'd1;
  assign w_yinc = {1'b0, r_ypos} + 11'd1;
  assign w_xsat = (r_xpos == C_MAX) ? C_MAX : w_xinc[9:0];
  assign w_ysat = (r_ypos == C_MAX) ? C_MAX : w_yinc[9:0];

  assign w_x_nxt = w_hfall ? 10'd0 : w_xsat;
  assign w_y_nxt = w_frame ? 10'd0 :
                   w_hfall ? w_ysat : r_ypos;

  assign w_bad = (w_hfall & (w_xinc != C_HT)) |
                 (w_frame & (w_yinc != C_VT)) |
                 (r_xpos == C_MAX) |
                 (r_ypos == C_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_fail      = 1'b0;
    unique case (r_state)
      UNLOCKED: begin
        if (w_frame) begin
          w_state_nxt = ACQUIRE;
          w_good_nxt  = 2'd0;
        end
      end
      ACQUIRE: begin
        if (w_bad) begin
          w_fail      = 1'b1;
          w_state_nxt = UNLOCKED;
        end else if (w_frame) begin
          w_good_nxt = r_good + 2'd1;
          if (w_good_nxt == C_LF) w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_bad) begin
          w_fail      = 1'b1;
          w_state_nxt = UNLOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  assign w_de_nxt = (w_state_nxt == LOCKED) &
                    (w_x_nxt >= C_HDS) & (w_x_nxt < C_HDE) &
                    (w_y_nxt >= C_VDS) & (w_y_nxt < C_VDE);

  always_ff @(posedge new_clk_25 or posedge reset) begin
    if (reset) begin
      r_state <= UNLOCKED;
      r_good  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Sync flops reset high so releasing reset never fakes an edge.
  always_ff @(posedge new_clk_25 or posedge reset) begin
    if (reset) begin
      r_hs1         <= 1'b1;
      r_hs2         <= 1'b1;
      r_hprev       <= 1'b1;
      r_vs1         <= 1'b1;
      r_vs2         <= 1'b1;
      r_vlast       <= 1'b1;
      r_xpos        <= 10'd0;
      r_ypos        <= 10'd0;
      r_line_len    <= 10'd0;
      r_frame_lines <= 10'd0;
      r_de          <= 1'b0;
      r_fs          <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_hs1   <= bus.hsync_in;
      r_hs2   <= r_hs1;
      r_hprev <= r_hs2;
      r_vs1   <= bus.vsync_in;
      r_vs2   <= r_vs1;
      if (w_hfall) begin
        r_vlast    <= r_vs2;
        r_line_len <= w_xsat;
      end
      if (w_frame) r_frame_lines <= w_ysat;
      r_xpos   <= w_x_nxt;
      r_ypos   <= w_y_nxt;
      r_de     <= w_de_nxt;
      r_fs     <= w_frame;
      r_err    <= w_fail;
      r_locked <= (r_state == LOCKED);
    end
  end

  assign bus.xpos        = r_xpos;
  assign bus.ypos        = r_ypos;
  assign bus.de          = r_de;
  assign bus.frame_start = r_fs;
  assign bus.line_len    = r_line_len;
  assign bus.frame_lines = r_frame_lines;
  assign bus.locked      = r_locked;
  assign bus.sync_err    = r_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench: a line/frame level sync source with an event
// model feeds expectations to a monitor watching the decoder.
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int VT  = 12;
  localparam int HS  = 4;
  localparam int VS  = 2;
  localparam int HDS = 8;
  localparam int HDE = 32;
  localparam int VDS = 3;
  localparam int VDE = 10;
  localparam int LF  = 2;
  localparam int DE_FRAME = (HDE - HDS) * (VDE - VDS);

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT),
    .H_DE_START(HDS), .H_DE_END(HDE),
    .V_DE_START(VDS), .V_DE_END(VDE),
    .LOCK_FRAMES(LF)
  ) dut (
    .new_clk_25(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit sat;
    bit chk_len;
    int len;
    bit fs;
    int fl;
    bit err;
    bit lk;
  } ev_t;

  ev_t q[$];
  int errors = 0;
  int checks = 0;

  // event-level reference state
  int m_st, m_good, m_ycnt, m_cnt;
  bit m_vlast, m_seen, prev_hs;
  int gen_x = 2000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic int sat10(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic bit win(input int x, input int y);
    return x >= HDS && x < HDE && y >= VDS && y < VDE;
  endfunction

  task automatic model_reset();
    m_st = 0; m_good = 0; m_ycnt = 0; m_cnt = 0;
    m_vlast = 1; m_seen = 0; prev_hs = 1;
  endtask

  task automatic do_fall(input bit vlow);
    ev_t e;
    int d;
    bit isf, bad;
    d = m_cnt + 1;
    isf = vlow && m_vlast;
    m_vlast = !vlow;
    e.sat = 0;
    e.chk_len = m_seen;
    e.len = sat10(d);
    e.fs = isf;
    e.fl = sat10(m_ycnt + 1);
    m_ycnt = isf ? 0 : sat10(m_ycnt + 1);
    bad = (d != HT) || (isf && e.fl != VT);
    e.err = 0;
    if (m_st != 0 && bad) begin
      e.err = 1;
      m_st = 0;
    end else if (isf) begin
      if (m_st == 0) begin
        m_st = 1; m_good = 0;
      end else if (m_st == 1) begin
        m_good++;
        if (m_good == LF) m_st = 2;
      end
    end
    e.lk = (m_st == 2);
    q.push_back(e);
    m_cnt = 0;
    m_seen = 1;
  endtask

  task automatic do_sat();
    ev_t e;
    e = '{sat: 1, chk_len: 0, len: 0, fs: 0, fl: 0,
          err: (m_st != 0), lk: 0};
    m_st = 0;
    q.push_back(e);
  endtask

  task automatic cyc(input bit hs, input bit vs);
    @(posedge clk);
    #2;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    if (prev_hs && !hs) begin
      do_fall(!vs);
    end else begin
      if (m_cnt < 100000) m_cnt++;
      if (m_cnt == 1023 && m_seen) do_sat();
    end
    gen_x = m_cnt;
    prev_hs = hs;
  endtask

  task automatic line(input int len, input bit vlow);
    for (int x = 0; x < len; x++) cyc(x >= HS, !vlow);
  endtask

  task automatic frame(input int nl, input int idx, input int l2);
    for (int y = 0; y < nl; y++) line((y == idx) ? l2 : HT, y < VS);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    chk("queue_empty_at_reset", q.size(), 0);
    q.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_xpos", bus.xpos, 0);
      chk("rst_ypos", bus.ypos, 0);
      chk("rst_line_len", bus.line_len, 0);
      chk("rst_frame_lines", bus.frame_lines, 0);
      chk("rst_flags", {bus.de, bus.frame_start, bus.locked,
                        bus.sync_err}, 0);
    end
    model_reset();
    gen_x = 2000;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // monitor
  initial begin
    int prev_x, h0, h1, h2, lk_dly, de_cnt;
    bit err_now, err_nxt, lk_exp, all_lk, have_fs, ln;
    ev_t e;
    prev_x = 0; lk_dly = 0; err_nxt = 0; have_fs = 0;
    h0 = 2000; h1 = 2000; h2 = 2000; all_lk = 0; de_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_x = 0; err_nxt = 0; lk_dly = 0; have_fs = 0;
        h0 = 2000; h1 = 2000; h2 = 2000;
        continue;
      end
      err_now = err_nxt;
      err_nxt = 0;
      if (lk_dly > 0) begin
        lk_dly--;
        if (lk_dly == 0) chk("locked", bus.locked, lk_exp);
      end
      ln = (bus.xpos == 0 && prev_x != 0);
      if (ln) begin
        if (q.size() == 0) begin
          chk("unexpected_line_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind_line", e.sat, 0);
          if (e.chk_len) chk("line_len", bus.line_len, e.len);
          chk("frame_start", bus.frame_start, e.fs);
          if (e.fs) chk("frame_lines", bus.frame_lines, e.fl);
          err_now = e.err;
          lk_exp = e.lk;
          lk_dly = 1;
        end
      end else begin
        if (bus.frame_start) chk("spurious_frame_start", 1, 0);
        if (bus.xpos == 1023 && prev_x == 1022) begin
          if (q.size() == 0) begin
            chk("unexpected_timeout_event", 1, 0);
          end else begin
            e = q.pop_front();
            chk("event_kind_timeout", e.sat, 1);
            err_nxt = e.err;
            lk_exp = e.lk;
            lk_dly = 2;
          end
        end
      end
      chk("sync_err", bus.sync_err, err_now);
      if (bus.locked && h2 < 1023) chk("xpos_delay3", bus.xpos, h2);
      if (bus.locked && !bus.sync_err)
        chk("de_window", bus.de, win(bus.xpos, bus.ypos));
      if (bus.de && !bus.locked) chk("de_without_lock", 1, 0);
      if (bus.frame_start) begin
        if (have_fs && all_lk) chk("de_per_frame", de_cnt, DE_FRAME);
        have_fs = 1; all_lk = 1; de_cnt = 0;
      end else begin
        all_lk = all_lk & bus.locked;
        de_cnt += int'(bus.de);
      end
      h2 = h1; h1 = h0; h0 = gen_x;
      prev_x = bus.xpos;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    model_reset();
    do_reset(3);
    repeat (5) frame(VT, -1, HT);
    frame(VT, int'($urandom_range(0, VT - 1)), HT - 1);
    repeat (4) frame(VT, -1, HT);
    frame(VT - 1, -1, HT);
    repeat (4) frame(VT, -1, HT);
    repeat (1100 + $urandom_range(0, 60)) cyc(1'b1, 1'b1);
    repeat (4) frame(VT, -1, HT);
    for (int i = 0; i < 14; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        1: frame(VT, int'($urandom_range(0, VT - 1)), HT - 1);
        2: frame(VT, int'($urandom_range(0, VT - 1)), HT + 1);
        3: frame(VT - 1, -1, HT);
        4: frame(VT + 1, -1, HT);
        default: frame(VT, -1, HT);
      endcase
    end
    repeat (3) frame(VT, -1, HT);
    for (int x = 0; x < HS + 6; x++) cyc(x >= HS, 1'b1);
    do_reset(4);
    repeat (5) frame(VT, -1, HT);
    repeat (12) cyc(1'b1, 1'b1);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
